seven_seg_scanner: RTL and testbench
====================================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles each digit is driven (legal >= 2).
REQ-002 SHALL have parameter GUARD, default 4, all-off cycles between digits (legal >= 1).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port en  input  1  scan enable.
REQ-006 SHALL have port data  input  16  four hex nibbles, data[3:0] = digit 0 (rightmost).
REQ-007 SHALL have port load  input  1  capture strobe for data.
REQ-008 SHALL have port blank  input  4  per-digit forced blank, bit k = digit k.
REQ-009 SHALL have port lz_en  input  1  leading-zero suppression enable.
REQ-010 SHALL have port an  output  4  digit anodes, active-low.
REQ-011 SHALL have port seg  output  7  segments {g..a}, active-low, hex glyphs 0-F.
REQ-012 SHALL have port digit_idx  output  2  index of digit currently in DRIVE.
REQ-013 SHALL have port load_ack  output  1  one-cycle pulse acknowledging a load.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse at frame boundary.

Function
REQ-015 SHALL implement states OFF, DRIVE, GUARD; SHALL use a cycle counter and 2-bit digit index.
REQ-016 OFF: en=1 -> DRIVE digit 0, counter 0, on next edge.
REQ-017 DRIVE: counter reaches SCAN_DIV-1 -> GUARD, counter 0; otherwise counter+1.
REQ-018 GUARD: counter reaches GUARD-1 -> DRIVE digit index+1 (3 wraps to 0), counter 0.
REQ-019 en=0 in any state -> OFF on next edge; digit index and counter cleared; pending load kept.
REQ-020 an and seg SHALL be registered and updated on the same edge as the state transition.
REQ-021 DRIVE digit k, not blanked: an = ~(1<<k), seg = hex glyph of shadow nibble k.
REQ-022 OFF, GUARD, or blanked digit: an = 4'hF, seg = 7'h7F.
REQ-023 Digit k blanked if blank[k]=1, or lz_en=1 and k>=1 and shadow nibbles k..3 all zero; digit 0 never suppressed by lz_en.
REQ-024 load=1 at an edge: data copied to pending register, pend flag set, load_ack=1 the following cycle.
REQ-025 Successive loads before a boundary: latest wins, earlier pending data discarded.
REQ-026 Frame boundary = GUARD->DRIVE transition from digit 3 to digit 0; shadow <= pending if pend, pend cleared, frame_done=1 for that one cycle.
REQ-027 load coincident with boundary: shadow SHALL take the new data; pend cleared.
REQ-028 In OFF, pend set -> shadow <= pending next edge (no tearing concern when dark).
REQ-029 Shadow SHALL change only at a boundary or in OFF; a displayed frame never mixes old and new data.
REQ-030 digit_idx SHALL hold the digit index in all states (0 in OFF).

Reset
REQ-031 rst_n=0 SHALL asynchronously force: state OFF, counter 0, digit 0, an=4'hF, seg=7'h7F, shadow 0, pending 0, pend 0, load_ack 0, frame_done 0.
REQ-032 Reset mid-scan or mid-load SHALL discard pending data; the first frame after release shows 0000 once en=1.
REQ-033 Release of rst_n SHALL be synchronous to clk; first state change no earlier than the first edge after release.

Structure
REQ-034 State encoding, glyph table constants (7'h7F blank), and the digit count SHALL live in shared package seg_pkg.
REQ-035 One sub-module: BCD, the team's hex-to-seven-segment active-low decoder, instantiated once and time-shared across digits via a 4:1 nibble mux.

Verification (SCAN_DIV=4, GUARD=1)
REQ-036 Reset, en=1, no load -> an cycles E,F,D,F,B,F,7,F; seg 7'h40 in DRIVE; frame period 20 cycles; frame_done every 20 cycles.
REQ-037 load data=16'h12AF mid-digit-1 -> load_ack next cycle; digits show F,A,2,1 starting at next boundary only; current frame unchanged.
REQ-038 lz_en=1, data=16'h0030 -> digits 3,2 blanked (an=F in their DRIVE slots), digit 1 seg=7'h30, digit 0 seg=7'h40; data=16'h0000 -> only digit 0 lit.
REQ-039 Two loads 16'h1111 then 16'h2222 within one frame -> next frame shows 2222; load coincident with boundary -> shown that frame.
REQ-040 en dropped during DRIVE digit 2 -> next cycle an=F, digit_idx=0; en re-raised -> DRIVE digit 0; rst_n pulsed mid-DRIVE -> outputs reset immediately, without a clock edge.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scanner: scan states, digit count
// and the active-low hex glyph table.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Segment order {g,f,e,d,c,b,a}, active-low; entry k is the glyph for hex k.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GUARD = 2'd2
  } scan_state_t;

endpackage

// File: rtl/bcd.sv
// Hex nibble to active-low seven-segment glyph decoder.
module bcd
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed four-digit seven-segment driver with guard gaps between
// digits, frame-synchronous data updates and leading-zero suppression.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] data,
  input  logic        load,
  input  logic [3:0]  blank,
  input  logic        lz_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic [1:0]  digit_idx,
  output logic        load_ack,
  output logic        frame_done
);

  localparam int CNT_MAX = (SCAN_DIV > GUARD) ? SCAN_DIV : GUARD;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  scan_state_t      state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       digit, digit_d;
  logic             boundary;

  logic [15:0]      shadow, shadow_d;
  logic [15:0]      pending, pending_d;
  logic             pend, pend_d;

  logic [3:0]       nib_sel;
  logic [6:0]       glyph;
  logic [3:0]       lz_mask;
  logic             zero_above;
  logic             dark;
  logic [3:0]       an_d;
  logic [6:0]       seg_d;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    digit_d  = digit;
    boundary = 1'b0;
    if (!en) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      digit_d = 2'd0;
    end else begin
      case (state)
        ST_OFF: begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
          digit_d = 2'd0;
        end
        ST_DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            state_d = ST_GUARD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CNT_ONE;
          end
        end
        ST_GUARD: begin
          if (cnt == GUARD_LAST) begin
            state_d  = ST_DRIVE;
            cnt_d    = '0;
            digit_d  = digit + 2'd1;
            boundary = (digit == 2'd3);
          end else begin
            cnt_d = cnt + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
          digit_d = 2'd0;
        end
      endcase
    end
  end

  // The shadow only moves at a frame boundary or while dark, so a frame is never torn.
  always_comb begin
    shadow_d  = shadow;
    pending_d = pending;
    pend_d    = pend;
    if (load) begin
      pending_d = data;
    end
    if (boundary) begin
      if (load) begin
        shadow_d = data;
      end else if (pend) begin
        shadow_d = pending;
      end
      pend_d = 1'b0;
    end else if (load) begin
      pend_d = 1'b1;
    end else if ((state == ST_OFF) && pend) begin
      shadow_d = pending;
      pend_d   = 1'b0;
    end
  end

  always_comb begin
    nib_sel = 4'h0;
    case (digit_d)
      2'd0: nib_sel = shadow_d[3:0];
      2'd1: nib_sel = shadow_d[7:4];
      2'd2: nib_sel = shadow_d[11:8];
      2'd3: nib_sel = shadow_d[15:12];
      default: nib_sel = 4'h0;
    endcase
  end

  bcd u_bcd (
    .nibble (nib_sel),
    .seg    (glyph)
  );

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    lz_mask    = 4'b0000;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (shadow_d[k*4 +: 4] == 4'h0);
      lz_mask[k] = zero_above;
    end
  end

  always_comb begin
    dark  = (state_d != ST_DRIVE) || blank[digit_d] || (lz_en && lz_mask[digit_d]);
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    if (!dark) begin
      an_d  = ~(4'b0001 << digit_d);
      seg_d = glyph;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_OFF;
      cnt        <= '0;
      digit      <= 2'd0;
      shadow     <= 16'h0000;
      pending    <= 16'h0000;
      pend       <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      digit      <= digit_d;
      shadow     <= shadow_d;
      pending    <= pending_d;
      pend       <= pend_d;
      an         <= an_d;
      seg        <= seg_d;
      load_ack   <= load;
      frame_done <= boundary;
    end
  end

  assign digit_idx = digit;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner with SCAN_DIV=4, GUARD=1
// (20-cycle frame: per digit four DRIVE cycles then one GUARD cycle).
module tb_seven_seg_scanner;

  localparam int SCAN_DIV = 4;
  localparam int GUARD    = 1;
  localparam int FRAME    = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] data;
  logic        load;
  logic [3:0]  blank;
  logic        lz_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [1:0]  digit_idx;
  logic        load_ack;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int pos    = 0;
  logic [15:0] shown = 16'h0000;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .GUARD    (GUARD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .data       (data),
    .load       (load),
    .blank      (blank),
    .lz_en      (lz_en),
    .an         (an),
    .seg        (seg),
    .digit_idx  (digit_idx),
    .load_ack   (load_ack),
    .frame_done (frame_done)
  );

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic lit(input int p, input logic [15:0] s, input logic [3:0] blk, input logic lz);
    int k;
    k = p / 5;
    if ((p % 5) == 4) return 1'b0;
    if (blk[k]) return 1'b0;
    if (lz) begin
      if (k == 3 && s[15:12] == 4'h0) return 1'b0;
      if (k == 2 && s[15:8] == 8'h00) return 1'b0;
      if (k == 1 && s[15:4] == 12'h000) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [3:0] exp_an(input int p, input logic [15:0] s, input logic [3:0] blk, input logic lz);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << (p / 5);
    return lit(p, s, blk, lz) ? ~one_hot : 4'hF;
  endfunction

  function automatic logic [6:0] exp_seg(input int p, input logic [15:0] s, input logic [3:0] blk, input logic lz);
    return lit(p, s, blk, lz) ? glyph(s[(p/5)*4 +: 4]) : 7'h7F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    pos = (pos + 1) % FRAME;
  endtask

  task automatic restart();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    pos = 0;
  endtask

  task automatic goto(input int p);
    while (pos != p) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; load = 1'b0; data = 16'h0000; blank = 4'h0; lz_en = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got %h want %h", an, 4'hF); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want %h", seg, 7'h7F); end
    checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL reset_digit got %0d want 0", digit_idx); end
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL reset_load_ack got %b want 0", load_ack); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL off_an got %h want %h", an, 4'hF); end
  endtask

  task automatic test_scan();
    shown = 16'h0000;
    restart();
    for (int i = 0; i <= 2 * FRAME; i++) begin
      checks++; if (an !== exp_an(pos, shown, 4'h0, 1'b0)) begin errors++; $display("FAIL scan_an cyc=%0d got %h want %h", i, an, exp_an(pos, shown, 4'h0, 1'b0)); end
      checks++; if (seg !== exp_seg(pos, shown, 4'h0, 1'b0)) begin errors++; $display("FAIL scan_seg cyc=%0d got %h want %h", i, seg, exp_seg(pos, shown, 4'h0, 1'b0)); end
      checks++; if (digit_idx !== 2'(pos / 5)) begin errors++; $display("FAIL scan_digit cyc=%0d got %0d want %0d", i, digit_idx, pos / 5); end
      checks++; if (frame_done !== ((i % FRAME) == 0 && i > 0)) begin errors++; $display("FAIL scan_frame_done cyc=%0d got %b want %b", i, frame_done, ((i % FRAME) == 0 && i > 0)); end
      tick();
    end
  endtask

  task automatic test_load();
    shown = 16'h0000;
    restart();
    goto(6);
    data = 16'h12AF; load = 1'b1;
    tick();
    load = 1'b0;
    checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL load_ack_pulse got %b want 1", load_ack); end
    tick();
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL load_ack_single got %b want 0", load_ack); end
    do begin
      checks++; if (seg !== exp_seg(pos, shown, 4'h0, 1'b0)) begin errors++; $display("FAIL load_old_frame pos=%0d got %h want %h", pos, seg, exp_seg(pos, shown, 4'h0, 1'b0)); end
      tick();
    end while (pos != 0);
    shown = 16'h12AF;
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL load_boundary_frame_done got %b want 1", frame_done); end
    for (int i = 0; i < FRAME; i++) begin
      checks++; if (an !== exp_an(pos, shown, 4'h0, 1'b0)) begin errors++; $display("FAIL load_new_an pos=%0d got %h want %h", pos, an, exp_an(pos, shown, 4'h0, 1'b0)); end
      checks++; if (seg !== exp_seg(pos, shown, 4'h0, 1'b0)) begin errors++; $display("FAIL load_new_seg pos=%0d got %h want %h", pos, seg, exp_seg(pos, shown, 4'h0, 1'b0)); end
      tick();
    end
  endtask

  task automatic test_lz();
    lz_en = 1'b1;
    data = 16'h0030; load = 1'b1;
    tick();
    load = 1'b0;
    restart();
    shown = 16'h0030;
    for (int i = 0; i < FRAME; i++) begin
      checks++; if (an !== exp_an(pos, shown, 4'h0, 1'b1)) begin errors++; $display("FAIL lz30_an pos=%0d got %h want %h", pos, an, exp_an(pos, shown, 4'h0, 1'b1)); end
      checks++; if (seg !== exp_seg(pos, shown, 4'h0, 1'b1)) begin errors++; $display("FAIL lz30_seg pos=%0d got %h want %h", pos, seg, exp_seg(pos, shown, 4'h0, 1'b1)); end
      tick();
    end
    data = 16'h0000; load = 1'b1;
    tick();
    load = 1'b0;
    restart();
    shown = 16'h0000;
    for (int i = 0; i < FRAME; i++) begin
      checks++; if (an !== exp_an(pos, shown, 4'h0, 1'b1)) begin errors++; $display("FAIL lz00_an pos=%0d got %h want %h", pos, an, exp_an(pos, shown, 4'h0, 1'b1)); end
      checks++; if (seg !== exp_seg(pos, shown, 4'h0, 1'b1)) begin errors++; $display("FAIL lz00_seg pos=%0d got %h want %h", pos, seg, exp_seg(pos, shown, 4'h0, 1'b1)); end
      tick();
    end
    lz_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    shown = 16'h0000;
    restart();
    goto(2);
    data = 16'h1111; load = 1'b1;
    tick();
    load = 1'b0;
    goto(8);
    data = 16'h2222; load = 1'b1;
    tick();
    load = 1'b0;
    do begin
      checks++; if (seg !== exp_seg(pos, shown, 4'h0, 1'b0)) begin errors++; $display("FAIL b2b_old_frame pos=%0d got %h want %h", pos, seg, exp_seg(pos, shown, 4'h0, 1'b0)); end
      tick();
    end while (pos != 0);
    shown = 16'h2222;
    for (int i = 0; i < FRAME; i++) begin
      checks++; if (seg !== exp_seg(pos, shown, 4'h0, 1'b0)) begin errors++; $display("FAIL b2b_latest pos=%0d got %h want %h", pos, seg, exp_seg(pos, shown, 4'h0, 1'b0)); end
      if (pos == 3) begin data = 16'h4444; load = 1'b1; end
      else if (pos == 19) begin data = 16'h3333; load = 1'b1; end
      else load = 1'b0;
      tick();
    end
    load = 1'b0;
    shown = 16'h3333;
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL coincident_frame_done got %b want 1", frame_done); end
    checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL coincident_load_ack got %b want 1", load_ack); end
    for (int i = 0; i <= FRAME; i++) begin
      checks++; if (seg !== exp_seg(pos, shown, 4'h0, 1'b0)) begin errors++; $display("FAIL coincident_seg pos=%0d got %h want %h", pos, seg, exp_seg(pos, shown, 4'h0, 1'b0)); end
      tick();
    end
  endtask

  task automatic test_blank();
    blank = 4'b0010;
    goto(0);
    for (int i = 0; i < FRAME; i++) begin
      checks++; if (an !== exp_an(pos, shown, blank, 1'b0)) begin errors++; $display("FAIL blank_an pos=%0d got %h want %h", pos, an, exp_an(pos, shown, blank, 1'b0)); end
      checks++; if (seg !== exp_seg(pos, shown, blank, 1'b0)) begin errors++; $display("FAIL blank_seg pos=%0d got %h want %h", pos, seg, exp_seg(pos, shown, blank, 1'b0)); end
      tick();
    end
    blank = 4'b0000;
  endtask

  task automatic test_enable_and_reset();
    goto(11);
    en = 1'b0;
    tick();
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL en_drop_an got %h want %h", an, 4'hF); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL en_drop_seg got %h want %h", seg, 7'h7F); end
    checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL en_drop_digit got %0d want 0", digit_idx); end
    tick();
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL en_hold_an got %h want %h", an, 4'hF); end
    en = 1'b1;
    tick();
    pos = 0;
    checks++; if (an !== 4'hE) begin errors++; $display("FAIL en_raise_an got %h want %h", an, 4'hE); end
    checks++; if (seg !== 7'h30) begin errors++; $display("FAIL en_raise_seg got %h want %h", seg, 7'h30); end
    checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL en_raise_digit got %0d want 0", digit_idx); end
    data = 16'h5555; load = 1'b1;
    tick();
    load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL async_reset_an got %h want %h", an, 4'hF); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL async_reset_seg got %h want %h", seg, 7'h7F); end
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL async_reset_load_ack got %b want 0", load_ack); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pos = 0;
    shown = 16'h0000;
    for (int i = 0; i <= FRAME; i++) begin
      checks++; if (an !== exp_an(pos, shown, 4'h0, 1'b0)) begin errors++; $display("FAIL post_reset_an pos=%0d got %h want %h", pos, an, exp_an(pos, shown, 4'h0, 1'b0)); end
      checks++; if (seg !== exp_seg(pos, shown, 4'h0, 1'b0)) begin errors++; $display("FAIL post_reset_seg pos=%0d got %h want %h", pos, seg, exp_seg(pos, shown, 4'h0, 1'b0)); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_lz();
    test_back_to_back();
    test_blank();
    test_enable_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
